wb_port_arbiter: RTL and testbench

//  Controller for the integer-register writeback mux. Arbitrates the single regfile

---
 rtl/wb_port_arbiter_if.sv | 38 +++
 rtl/wb_port_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle between the result sources / issue stage and the
// writeback arbiter. The master side is the pipeline (sources, issue stage);
// the slave side is the arbiter that owns the regfile write port.
interface wb_port_arbiter_if;
    logic        mem_issue;
    logic [4:0]  mem_issue_rd;
    logic        load_credit_ok;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic        fpu_valid;
    logic [4:0]  fpu_rd;
    logic        fpu_ready;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic        alu_link;
    logic        alu_ready;
    logic        is_memread;
    logic        is_fromfloat;
    logic        is_address;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic        cred_err;
    logic [31:0] sb_busy;

    modport master (
        output mem_issue, mem_issue_rd, mem_valid, mem_rd,
               fpu_valid, fpu_rd, alu_valid, alu_rd, alu_link,
        input  load_credit_ok, fpu_ready, alu_ready, is_memread, is_fromfloat,
               is_address, wb_we, wb_rd, cred_err, sb_busy
    );

    modport slave (
        input  mem_issue, mem_issue_rd, mem_valid, mem_rd,
               fpu_valid, fpu_rd, alu_valid, alu_rd, alu_link,
        output load_credit_ok, fpu_ready, alu_ready, is_memread, is_fromfloat,
               is_address, wb_we, wb_rd, cred_err, sb_busy
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Integer regfile writeback arbiter.
// Shares the single write port between load returns, FPU->int moves and ALU
// results (mem > starved fpu > alu > fpu), drives the writeback mux selects,
// and keeps a load-credit counter so the issue stage cannot overrun the
// load return path.
// Optional build macro WB_SCOREBOARD_EN adds a per-register pending-load mask
// (sb_busy); without it sb_busy reads 0 and no mask flops exist.
module wb_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int MAX_LOADS  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    wb_port_arbiter_if.slave bus
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [2:0] LOAD_LIM   = 3'(MAX_LOADS);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic [2:0] out_cnt_q, out_cnt_d;
    logic       cred_err_q, cred_err_d;

    logic       starved;
    logic       alu_ready, fpu_ready;
    logic       mem_gnt, fpu_gnt, alu_gnt;
    logic [4:0] rd_sel;
    logic       credit_ok, issue_ok, ret_ok;

    // Combinational grant: outputs are forced idle while reset is asserted.
    always_comb begin
        starved   = (starve_cnt_q == STARVE_LIM);
        alu_ready = rst_n & ~bus.mem_valid & ~(bus.fpu_valid & starved);
        fpu_ready = rst_n & ~bus.mem_valid & (starved | ~bus.alu_valid);
        mem_gnt   = rst_n & bus.mem_valid;
        fpu_gnt   = bus.fpu_valid & fpu_ready;
        alu_gnt   = bus.alu_valid & alu_ready;
        rd_sel    = 5'd0;
        if (mem_gnt) begin
            rd_sel = bus.mem_rd;
        end else if (fpu_gnt) begin
            rd_sel = bus.fpu_rd;
        end else if (alu_gnt) begin
            rd_sel = bus.alu_rd;
        end
    end

    assign bus.alu_ready    = alu_ready;
    assign bus.fpu_ready    = fpu_ready;
    assign bus.is_memread   = mem_gnt;
    assign bus.is_fromfloat = fpu_gnt;
    assign bus.is_address   = alu_gnt & bus.alu_link;
    assign bus.wb_rd        = rd_sel;
    // x0 writes are still granted and consumed, just never written.
    assign bus.wb_we        = (mem_gnt | fpu_gnt | alu_gnt) & (rd_sel != 5'd0);

    // Next-state for the FPU starvation counter, load credits and error flag.
    always_comb begin
        starve_cnt_d = 4'd0;
        if (bus.fpu_valid && !fpu_ready) begin
            starve_cnt_d = starved ? starve_cnt_q : starve_cnt_q + 4'd1;
        end

        credit_ok = (out_cnt_q < LOAD_LIM);
        issue_ok  = bus.mem_issue & credit_ok;
        ret_ok    = bus.mem_valid & (out_cnt_q != 3'd0);
        out_cnt_d = out_cnt_q;
        if (issue_ok && !ret_ok) begin
            out_cnt_d = out_cnt_q + 3'd1;
        end else if (ret_ok && !issue_ok) begin
            out_cnt_d = out_cnt_q - 3'd1;
        end

        cred_err_d = cred_err_q
                   | (bus.mem_issue & ~credit_ok)
                   | (bus.mem_valid & (out_cnt_q == 3'd0));
    end

    assign bus.load_credit_ok = credit_ok;
    assign bus.cred_err       = cred_err_q;

    // Counter and sticky error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 4'd0;
            out_cnt_q    <= 3'd0;
            cred_err_q   <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            out_cnt_q    <= out_cnt_d;
            cred_err_q   <= cred_err_d;
        end
    end

`ifdef WB_SCOREBOARD_EN
    logic [31:0] sb_busy_q, sb_busy_d;

    // Pending-load mask: a new issue to r outranks a same-cycle return to r.
    always_comb begin
        sb_busy_d = sb_busy_q;
        if (bus.mem_valid) begin
            sb_busy_d[bus.mem_rd] = 1'b0;
        end
        if (issue_ok && (bus.mem_issue_rd != 5'd0)) begin
            sb_busy_d[bus.mem_issue_rd] = 1'b1;
        end
        sb_busy_d[0] = 1'b0;
    end

    // Pending-load mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_busy_q <= 32'h0;
        end else begin
            sb_busy_q <= sb_busy_d;
        end
    end

    assign bus.sb_busy = sb_busy_q;
`else
    logic unused_issue_rd;
    assign unused_issue_rd = ^bus.mem_issue_rd;
    assign bus.sb_busy     = 32'h0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: stimulus drives directed and random cycles and
// pushes the reference model's expected outputs; a monitor pops and compares.
module tb_wb_port_arbiter;

    localparam int SM = 4;
    localparam int ML = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.STARVE_MAX(SM), .MAX_LOADS(ML)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [5:0]  ctl;   // alu_ready, fpu_ready, is_memread, is_fromfloat, is_address, wb_we
        logic [4:0]  rd;
        logic        cok;
        logic        cerr;
        logic [31:0] sb;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference state, tracked as plain numbers.
    int          m_starve = 0;
    int          m_out = 0;
    bit          m_cerr = 0;
    logic [31:0] m_sb = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the clock edge and push the expectation.
    task automatic step(input logic rn, input logic mv, input logic [4:0] mrd,
                        input logic fv, input logic [4:0] frd,
                        input logic av, input logic [4:0] ard, input logic al,
                        input logic mi, input logic [4:0] mird);
        exp_t e;
        string winner;
        logic [4:0] wrd;
        bit starved, a_rdy, f_rdy, iss_ok, ret_ok;
        @(posedge clk);
        #1;
        rst_n = rn;
        bus.mem_valid = mv;  bus.mem_rd = mrd;
        bus.fpu_valid = fv;  bus.fpu_rd = frd;
        bus.alu_valid = av;  bus.alu_rd = ard;  bus.alu_link = al;
        bus.mem_issue = mi;  bus.mem_issue_rd = mird;
        e = '0;
        if (!rn) begin
            m_starve = 0; m_out = 0; m_cerr = 0; m_sb = 32'h0;
            e.cok = 1'b1;
            exp_q.push_back(e);
            return;
        end
        starved = (m_starve == SM);
        a_rdy = !mv && !(fv && starved);
        f_rdy = !mv && (starved || !av);
        if (mv)                  begin winner = "mem"; wrd = mrd; end
        else if (fv && starved)  begin winner = "fpu"; wrd = frd; end
        else if (av)             begin winner = "alu"; wrd = ard; end
        else if (fv)             begin winner = "fpu"; wrd = frd; end
        else                     begin winner = "none"; wrd = 5'd0; end
        e.ctl = {a_rdy, f_rdy, winner == "mem", winner == "fpu",
                 winner == "alu" && al, winner != "none" && wrd != 5'd0};
        e.rd   = wrd;
        e.cok  = (m_out < ML);
        e.cerr = m_cerr;
        `ifdef WB_SCOREBOARD_EN
        e.sb = m_sb;
        `else
        e.sb = 32'h0;
        `endif
        exp_q.push_back(e);
        // advance the model to the state after the coming edge
        if (fv && winner != "fpu") m_starve = (m_starve + 1 > SM) ? SM : m_starve + 1;
        else m_starve = 0;
        iss_ok = mi && (m_out < ML);
        ret_ok = mv && (m_out > 0);
        if ((mi && !iss_ok) || (mv && m_out == 0)) m_cerr = 1;
        m_out = m_out + int'(iss_ok) - int'(ret_ok);
        if (mv) m_sb[mrd] = 1'b0;
        if (iss_ok && mird != 0) m_sb[mird] = 1'b1;
        m_sb[0] = 1'b0;
    endtask

    task automatic idle(input logic rn);
        step(rn, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare DUT outputs against the queued expectation mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("ctl", 32'({bus.alu_ready, bus.fpu_ready, bus.is_memread,
                            bus.is_fromfloat, bus.is_address, bus.wb_we}), 32'(e.ctl));
            chk("wb_rd", 32'(bus.wb_rd), 32'(e.rd));
            chk("load_credit_ok", 32'(bus.load_credit_ok), 32'(e.cok));
            chk("cred_err", 32'(bus.cred_err), 32'(e.cerr));
            chk("sb_busy", bus.sb_busy, e.sb);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got=timeout expected=finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.mem_valid = 0; bus.mem_rd = 0; bus.fpu_valid = 0; bus.fpu_rd = 0;
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_link = 0;
        bus.mem_issue = 0; bus.mem_issue_rd = 0;
        idle(0);
        idle(0);
        idle(1);
        // ALU link write to x3
        step(1, 0, 0, 0, 0, 1, 3, 1, 0, 0);
        // load return beats ALU and FPU (with credit error: nothing outstanding)
        step(1, 1, 7, 1, 9, 1, 4, 0, 0, 0);
        idle(0); idle(1);
        // ALU vs FPU held: FPU wins once starved
        repeat (6) step(1, 0, 0, 1, 11, 1, 12, 0, 0, 0);
        idle(1);
        // credits: three issues, then issue+return together
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 5);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 6);
        step(1, 0, 0, 0, 0, 0, 0, 0, 1, 8);
        step(1, 1, 5, 0, 0, 0, 0, 0, 1, 5);
        step(1, 1, 6, 0, 0, 0, 0, 0, 1, 5);
        step(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
        // x0 ALU writes consumed without write, reset mid-burst
        repeat (3) step(1, 0, 0, 0, 0, 1, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 1, 0, 0, 1, 2);
        idle(0);
        idle(1);
        // randomized traffic with periodic resets
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 249) begin
                idle(0);
            end else begin
                step(1, ($urandom_range(0, 99) < 25), 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)),
                     ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)),
                     1'($urandom_range(0, 1)),
                     ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)));
            end
        end
        idle(1);
        repeat (2) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
